xbar_target_responder: RTL and testbench
========================================

// Module: xbar_target_responder
// PURPOSE
//   Target-side end of the 2x2 crossbar request/grant/acknowledge protocol; one instance per target port.
//   Watches the arbiter's one-hot grant and captures the granted master's command (addr/wdata/we).
//   Runs the command on a simple memory back-end, then returns a one-cycle acknowledge plus read data.
//   Its acknowledge output feeds the arbiter's acknowledge input, so the arbiter can rotate priority.
// PARAMETERS
//   AW            8    address width, bits
//   DW            32   data width, bits
//   TIMEOUT_CYC   16   back-end wait limit in cycles, >=2 (used only with the timeout feature)
// PORTS
//   clock        in   1    single clock, rising edge
//   reset_n      in   1    asynchronous, active-low reset
//   grant        in   2    one-hot grant from the arbiter; bit i = master i
//   m0_addr      in   AW   master 0 address
//   m0_wdata     in   DW   master 0 write data
//   m0_we        in   1    master 0 write enable (1 = write, 0 = read)
//   m1_addr      in   AW   master 1 address
//   m1_wdata     in   DW   master 1 write data
//   m1_we        in   1    master 1 write enable
//   acknowledge  out  2    one-hot completion pulse to the arbiter and masters
//   rdata        out  DW   read data; valid while acknowledge != 0
//   error        out  1    transfer aborted; valid while acknowledge != 0
//   mem_req      out  1    back-end request, held until mem_ready
//   mem_we       out  1    back-end write enable
//   mem_addr     out  AW   back-end address
//   mem_wdata    out  DW   back-end write data
//   mem_ready    in   1    back-end completion; mem_rdata is valid in the same cycle
//   mem_rdata    in   DW   back-end read data
// BEHAVIOUR
//   - Reset (async assert, sync release): every output is 0; FSM goes to IDLE; internal index/command regs are 0.
//   - Reset asserted mid-transfer: mem_req drops immediately and no acknowledge is issued.
//   - FSM states: IDLE, ISSUE, ACK, RELEASE. All outputs are registered.
//   - IDLE, grant == 2'b01 or 2'b10:
//       latch idx = granted master plus that master's addr, wdata and we; go to ISSUE.
//   - IDLE, grant == 2'b00 or 2'b11: stay in IDLE. 2'b11 is illegal and is ignored.
//   - ISSUE: mem_req=1; mem_addr, mem_we and mem_wdata come from the latched regs.
//       Latched command stays stable even if the master changes its inputs.
//   - ISSUE, mem_ready=1: capture mem_rdata (write: rdata=0); mem_req drops next cycle; go to ACK.
//   - ACK: acknowledge[idx]=1 for exactly one cycle, with rdata and error driven; go to RELEASE.
//   - RELEASE: wait for grant == 0, then go to IDLE. This blocks a double transfer on a stale grant.
//   - Grant withdrawn during ISSUE: the transfer still completes and is acknowledged.
//   - Latency: grant seen in cycle N -> mem_req in N+1 -> ack in cycle M+1, where M is the mem_ready cycle.
//       Minimum: 0-wait back-end gives ack at N+2.
//   - acknowledge is never 2'b11; at most one transfer is in flight.
//   - rdata and error return to 0 the cycle after ACK.
// CONFIGURATION
//   TARGET_TIMEOUT_EN defined:
//     - Counter (width $clog2(TIMEOUT_CYC)+1) clears on entry to ISSUE and counts ISSUE cycles.
//     - At TIMEOUT_CYC ISSUE cycles without mem_ready: mem_req drops, go to ACK with error=1 and rdata=0.
//     - mem_ready in the same cycle as expiry wins: normal completion, error=0.
//   TARGET_TIMEOUT_EN undefined:
//     - No counter; ISSUE waits for mem_ready indefinitely.
//     - error is tied to 0; the port is always present.
// TESTING
//   1. Master 0 read, addr=0x10, 0-wait back-end returning 0xCAFEF00D
//      -> mem_req at N+1; acknowledge=2'b01 at N+2 for 1 cycle; rdata=0xCAFEF00D.
//   2. Master 1 write, addr=0x22, wdata=0x12345678, mem_ready after 3 cycles
//      -> mem_we=1 and mem_wdata stable for 4 cycles; acknowledge=2'b10 once; rdata=0.
//   3. Grant held high for 5 cycles after ack -> exactly one mem_req transaction;
//      return to IDLE only after grant=0.
//   4. grant=2'b11 for 3 cycles -> mem_req stays 0 and acknowledge stays 0.
//   5. reset_n low during ISSUE -> mem_req=0 asynchronously; no ack; after release a new grant works normally.
//   6. TARGET_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ready never
//      -> ack after 16 ISSUE cycles with error=1 and rdata=0.
//      Without the macro: no ack within 100 cycles.

Source files
------------

// File: rtl/xbar_target_responder.sv
// Target-side responder: latches the granted master's command, runs it on the memory back-end and returns a one-cycle acknowledge.
// Latency grant->mem_req 1 cycle, mem_ready->ack 1 cycle; mem_req is held until mem_ready; optional back-end timeout via TARGET_TIMEOUT_EN.
module xbar_target_responder #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [1:0]    grant,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic [1:0]    acknowledge,
  output logic [DW-1:0] rdata,
  output logic          error,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, RELEASE} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } cmd_t;

  typedef logic [$clog2(TIMEOUT_CYC):0] cnt_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic          idx_q, idx_d;
  logic          req_q, req_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_d;

`ifdef TARGET_TIMEOUT_EN
  cnt_t cnt_q, cnt_d;
  logic err_q;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    req_d   = req_q;
    ack_d   = 2'b00;
    rdata_d = '0;
    err_d   = 1'b0;
`ifdef TARGET_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // 2'b11 is an illegal grant and is ignored along with 2'b00
        if (grant == 2'b01) begin
          idx_d   = 1'b0;
          cmd_d   = '{addr: m0_addr, wdata: m0_wdata, we: m0_we};
          req_d   = 1'b1;
          state_d = ISSUE;
        end else if (grant == 2'b10) begin
          idx_d   = 1'b1;
          cmd_d   = '{addr: m1_addr, wdata: m1_wdata, we: m1_we};
          req_d   = 1'b1;
          state_d = ISSUE;
        end
`ifdef TARGET_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ISSUE: begin
        if (mem_ready) begin
          req_d   = 1'b0;
          ack_d   = idx_q ? 2'b10 : 2'b01;
          rdata_d = cmd_q.we ? '0 : mem_rdata;
          state_d = ACK;
        end
`ifdef TARGET_TIMEOUT_EN
        else if (cnt_q == cnt_t'(TIMEOUT_CYC - 1)) begin
          req_d   = 1'b0;
          ack_d   = idx_q ? 2'b10 : 2'b01;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK: state_d = RELEASE;
      // Hold off until the arbiter drops the grant so a stale grant cannot re-issue
      RELEASE: if (grant == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      idx_q   <= 1'b0;
      req_q   <= 1'b0;
      ack_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef TARGET_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign error = err_q;
`else
  assign error = err_d & 1'b0;
`endif

  assign acknowledge = ack_q;
  assign rdata       = rdata_q;
  assign mem_req     = req_q;
  assign mem_we      = cmd_q.we;
  assign mem_addr    = cmd_q.addr;
  assign mem_wdata   = cmd_q.wdata;

endmodule

// File: tb/tb_xbar_target_responder.sv
// Directed bench for xbar_target_responder with a back-end model and response/command scoreboards.
module tb_xbar_target_responder;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [1:0]    grant;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_we, m1_we;
  logic [1:0]    acknowledge;
  logic [DW-1:0] rdata;
  logic          error;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata;

  typedef struct packed {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } cmd_t;

  rsp_t          exp_q[$];
  cmd_t          cmd_q[$];
  rsp_t          mon_e;
  int            tests = 0, fails = 0;
  int            ack_cnt = 0, be_txn = 0, be_cnt = 0, be_wait = 0, last_req_cycles = 0;
  logic [DW-1:0] be_rdata = '0;

  assign mem_rdata = be_rdata;

  always #5 clock = ~clock;

  xbar_target_responder #(.AW(AW), .DW(DW), .TIMEOUT_CYC(16)) dut (
    .clock(clock), .reset_n(reset_n), .grant(grant),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .acknowledge(acknowledge), .rdata(rdata), .error(error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Back-end: ready after be_wait stall cycles (negative = never); command must match the scoreboard head
  always @(negedge clock) begin
    if (mem_req && reset_n) begin
      chk("be_pending_cmd", 64'(cmd_q.size() != 0), 64'd1);
      if (cmd_q.size() != 0) chk("mem_cmd", {mem_addr, mem_wdata, mem_we}, cmd_q[0]);
      if (be_cnt == be_wait) begin
        mem_ready = 1'b1;
        be_txn++;
        last_req_cycles = be_cnt + 1;
        if (cmd_q.size() != 0) void'(cmd_q.pop_front());
      end else begin
        mem_ready = 1'b0;
      end
      be_cnt++;
    end else begin
      mem_ready = 1'b0;
      be_cnt = 0;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (acknowledge != 2'b00) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", acknowledge, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_ack", acknowledge, mon_e.ack);
          chk("sb_rdata", rdata, mon_e.rdata);
          chk("sb_error", error, mon_e.err);
        end
      end else begin
        chk("idle_rdata_error", {error, rdata}, 64'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input bit m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic w, input logic [DW-1:0] brd, input int bw);
    be_rdata = brd;
    be_wait  = bw;
    cmd_q.push_back('{a, wd, w});
    exp_q.push_back('{(m ? 2'b10 : 2'b01), (w ? {DW{1'b0}} : brd), 1'b0});
    if (m) begin
      m1_addr = a; m1_wdata = wd; m1_we = w;
    end else begin
      m0_addr = a; m0_wdata = wd; m0_we = w;
    end
    grant = m ? 2'b10 : 2'b01;
  endtask

  task automatic wait_ack(input string name, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (acknowledge == 2'b00 && cyc < limit);
    chk({name, "_ack_seen"}, 64'(acknowledge != 2'b00), 64'd1);
  endtask

  initial begin
    int cyc, t0, a0;
    reset_n = 1'b0; grant = 2'b00;
    m0_addr = '0; m0_wdata = '0; m0_we = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_we = 1'b0;
    tick(2);
    chk("rst_ack", acknowledge, 64'd0);
    chk("rst_rdata_err", {error, rdata}, 64'd0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 64'd0);
    reset_n = 1'b1;
    tick(2);
    chk("post_rst_req", mem_req, 64'd0);

    // 1: master 0 read, zero-wait back-end
    issue(1'b0, 8'h10, 32'h0, 1'b0, 32'hCAFEF00D, 0);
    tick(1);
    chk("t1_req_n1", mem_req, 64'd1);
    chk("t1_ack_n1", acknowledge, 64'd0);
    tick(1);
    chk("t1_ack_n2", acknowledge, 64'd1);
    chk("t1_rdata", rdata, 64'hCAFEF00D);
    chk("t1_req_drop", mem_req, 64'd0);
    grant = 2'b00;
    tick(1);
    chk("t1_ack_pulse", acknowledge, 64'd0);
    chk("t1_rdata_clr", rdata, 64'd0);
    tick(2);

    // 2: master 1 write, 3 stall cycles; master inputs scrambled while in flight
    issue(1'b1, 8'h22, 32'h12345678, 1'b1, 32'hDEADBEEF, 3);
    tick(1);
    chk("t2_req", mem_req, 64'd1);
    chk("t2_we", mem_we, 64'd1);
    m1_addr = 8'hFF; m1_wdata = 32'h0BAD0BAD; m1_we = 1'b0;
    wait_ack("t2", 20, cyc);
    chk("t2_ack", acknowledge, 64'd2);
    chk("t2_rdata_zero", rdata, 64'd0);
    chk("t2_req_cycles", last_req_cycles, 64'd4);
    grant = 2'b00;
    tick(1);
    chk("t2_ack_once", acknowledge, 64'd0);
    tick(2);

    // 3: grant held after ack must not start a second transfer
    t0 = be_txn;
    issue(1'b0, 8'h30, 32'h0, 1'b0, 32'hA5A55A5A, 1);
    wait_ack("t3", 20, cyc);
    repeat (5) begin
      tick(1);
      chk("t3_no_req", mem_req, 64'd0);
      chk("t3_no_ack", acknowledge, 64'd0);
    end
    chk("t3_one_txn", be_txn - t0, 64'd1);
    grant = 2'b00;
    tick(2);

    // 4: illegal grant 2'b11 is ignored
    grant = 2'b11;
    repeat (3) begin
      tick(1);
      chk("t4_no_req", mem_req, 64'd0);
      chk("t4_no_ack", acknowledge, 64'd0);
    end
    grant = 2'b00;
    tick(1);

    // 5: reset in the middle of ISSUE
    a0 = ack_cnt;
    issue(1'b1, 8'h44, 32'h0, 1'b0, 32'h11112222, -1);
    tick(3);
    chk("t5_req_before", mem_req, 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("t5_req_async", mem_req, 64'd0);
    chk("t5_ack_async", acknowledge, 64'd0);
    exp_q.delete();
    cmd_q.delete();
    grant = 2'b00;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("t5_no_ack", ack_cnt - a0, 64'd0);
    chk("t5_mem_cleared", {mem_we, mem_addr, mem_wdata}, 64'd0);
    issue(1'b0, 8'h55, 32'hFEEDBEEF, 1'b1, 32'h77777777, 1);
    wait_ack("t5_after", 20, cyc);
    chk("t5_after_ack", acknowledge, 64'd1);
    grant = 2'b00;
    tick(2);

    // 6: back-end that never answers
    a0 = ack_cnt;
    issue(1'b0, 8'h66, 32'h0, 1'b0, 32'h99999999, -1);
`ifdef TARGET_TIMEOUT_EN
    void'(exp_q.pop_back());
    exp_q.push_back('{2'b01, {DW{1'b0}}, 1'b1});
    wait_ack("t6", 40, cyc);
    chk("t6_latency", cyc, 64'd17);
    chk("t6_error", error, 64'd1);
    chk("t6_rdata", rdata, 64'd0);
    chk("t6_req_drop", mem_req, 64'd0);
    cmd_q.delete();
    grant = 2'b00;
    tick(2);
`else
    exp_q.delete();
    tick(100);
    chk("t6_no_ack", ack_cnt - a0, 64'd0);
    chk("t6_req_held", mem_req, 64'd1);
    reset_n = 1'b0;
    cmd_q.delete();
    grant = 2'b00;
    tick(2);
    reset_n = 1'b1;
    tick(2);
`endif

    chk("sb_empty", exp_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
